// File: rtl/axi4_lite_pkg.sv
// Shared types for the posted-write store buffer: queued entry layout and issue FSM states.
// No logic here; widths match the store buffer's default parameters.
package axi4_lite_pkg;

  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;
  localparam int WORD_LSB      = 2;

  typedef struct packed {
    logic [SB_ADDR_WIDTH-1:0]   addr;
    logic [SB_DATA_WIDTH-1:0]   data;
    logic [SB_DATA_WIDTH/8-1:0] strobe;
  } store_entry_t;

  typedef enum logic [1:0] {
    SB_IDLE  = 2'd0,
    SB_ISSUE = 2'd1,
    SB_BUSY  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Generic DEPTH-entry FIFO with per-slot valid bits and a per-slot key field exported for comparators.
// Push lands in one cycle; head is read combinationally; the caller owns full/empty gating via count.
module sb_fifo #(
  parameter  int WIDTH   = 8,
  parameter  int DEPTH   = 4,
  parameter  int KEY_LSB = 0,
  parameter  int KEY_W   = 1,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic [DEPTH*KEY_W-1:0] keys,
  output logic [DEPTH-1:0]       valid,
  output logic [CW-1:0]          count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  // Pointers wrap naturally at DEPTH (power of two); full vs empty comes from count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      if (push) begin
        tail        <= tail + 1'b1;
        valid[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + 1'b1;
        valid[head] <= 1'b0;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_dat;
  end

  always_comb begin
    head_dat = mem[head];
    keys     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keys[i*KEY_W +: KEY_W] = mem[i][KEY_LSB +: KEY_W];
    end
  end

endmodule

// File: rtl/axi4_lite_store_buffer.sv
// Posted-write store buffer: one-cycle store accept, FIFO issue to the write master, load hazard flag.
// Latency: first write_start one cycle after accept; st_ready drops at DEPTH entries including the in-flight one.
module axi4_lite_store_buffer
  import axi4_lite_pkg::*;
#(
  parameter  int ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter  int DATA_WIDTH = SB_DATA_WIDTH,
  parameter  int DEPTH      = 4,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [STRB_W-1:0]     st_strobe,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_hazard,
  output logic                  write_start,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [STRB_W-1:0]     write_strobe,
  input  logic                  write_busy,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  localparam int EW      = $bits(store_entry_t);
  localparam int KEY_W   = ADDR_WIDTH - WORD_LSB;
  localparam int KEY_LSB = DATA_WIDTH + STRB_W + WORD_LSB;

  sb_state_t          state;
  sb_state_t          state_nxt;
  logic               push;
  logic               pop;
  logic               load;
  store_entry_t       push_ent;
  store_entry_t       head_ent;
  logic [EW-1:0]      head_raw;
  logic [DEPTH*KEY_W-1:0] ent_keys;
  logic [DEPTH-1:0]   ent_vld;
  logic               unused_ld_lsb;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot early.
  assign st_ready = (count != CW'(DEPTH));
  // Zero-strobe stores are handshaken but never occupy an entry.
  assign push     = st_valid && st_ready && (st_strobe != '0);

  always_comb begin
    push_ent        = '0;
    push_ent.addr   = st_addr;
    push_ent.data   = st_data;
    push_ent.strobe = st_strobe;
  end

  assign head_ent = store_entry_t'(head_raw);

  sb_fifo #(
    .WIDTH   (EW),
    .DEPTH   (DEPTH),
    .KEY_LSB (KEY_LSB),
    .KEY_W   (KEY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_raw),
    .keys     (ent_keys),
    .valid    (ent_vld),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SB_IDLE;
    else        state <= state_nxt;
  end

  // The head stays queued (and hazard-visible) until the master drops busy.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      SB_IDLE: begin
        if (count != '0) begin
          load      = 1'b1;
          state_nxt = SB_ISSUE;
        end
      end
      SB_ISSUE: begin
        if (write_busy) state_nxt = SB_BUSY;
      end
      SB_BUSY: begin
        if (!write_busy) begin
          pop       = 1'b1;
          state_nxt = SB_IDLE;
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_start  <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      write_strobe <= '0;
    end else begin
      write_start <= load;
      if (load) begin
        write_addr   <= head_ent.addr;
        write_data   <= head_ent.data;
        write_strobe <= head_ent.strobe;
      end
    end
  end

  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_keys[i*KEY_W +: KEY_W] == ld_addr[ADDR_WIDTH-1:WORD_LSB])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  // Byte offset within the word never participates in the hazard match.
  assign unused_ld_lsb = ^ld_addr[WORD_LSB-1:0];

  assign empty = (count == '0) && (state == SB_IDLE);

endmodule

// File: tb/tb_axi4_lite_store_buffer.sv
// Directed bench for axi4_lite_store_buffer with a behavioural write master and word memory.
// Stalls on the master are controlled from the stimulus to force full, hazard and same-cycle push/pop cases.
module tb_axi4_lite_store_buffer;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic [SW-1:0] st_strobe = '0;
  logic          st_ready;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hazard;
  logic          write_start;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [SW-1:0] write_strobe;
  logic          write_busy;
  logic [CW-1:0] count;
  logic          empty;

  int checks   = 0;
  int failures = 0;

  logic          stall    = 1'b0;
  logic          clr_word = 1'b0;
  int            busy_left;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic [SW-1:0] cap_strb;
  logic [DW-1:0] data_mem [16];
  logic [AW-1:0] log_addr [32];
  logic [DW-1:0] log_data [32];
  int            nlog      = 0;
  int            start_cnt = 0;

  always #5 clk = ~clk;

  axi4_lite_store_buffer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_strobe    (st_strobe),
    .st_ready     (st_ready),
    .ld_addr      (ld_addr),
    .ld_hazard    (ld_hazard),
    .write_start  (write_start),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .write_busy   (write_busy),
    .count        (count),
    .empty        (empty)
  );

  // Write master: busy the edge after write_start, two busy cycles (longer while stalled), commit on drop.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_busy <= 1'b0;
      busy_left  <= 0;
      for (int i = 0; i < 16; i++) data_mem[i] <= '0;
    end else begin
      if (clr_word) data_mem[2] <= '0;
      if (write_start && !write_busy) begin
        write_busy <= 1'b1;
        busy_left  <= 2;
        cap_addr   <= write_addr;
        cap_data   <= write_data;
        cap_strb   <= write_strobe;
      end else if (write_busy && !stall) begin
        if (busy_left > 1) begin
          busy_left <= busy_left - 1;
        end else begin
          write_busy <= 1'b0;
          for (int b = 0; b < SW; b++) begin
            if (cap_strb[b]) data_mem[cap_addr[5:2]][8*b +: 8] <= cap_data[8*b +: 8];
          end
          log_addr[nlog] <= cap_addr;
          log_data[nlog] <= cap_data;
          nlog           <= nlog + 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (write_start) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    int   n = 0;
    logic ok;
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_strobe = s;
    do begin
      ok = st_ready;
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!ok && n < 100);
    st_valid  = 1'b0;
    st_strobe = '0;
    chk("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!write_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(write_start), 64'd1);
  endtask

  task automatic wait_empty(input string tag);
    int n = 0;
    while (!empty && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(empty), 64'd1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n = 0;
    while (write_busy !== lvl && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(write_busy), 64'(lvl));
  endtask

  initial begin
    int base;
    int start0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_write_start", 64'(write_start), 64'd0);
    chk("rst_write_addr", 64'(write_addr), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_write_strobe", 64'(write_strobe), 64'd0);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ld_hazard", 64'(ld_hazard), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single store
    push(32'h04, 32'hDEAD_BEEF, 4'hF);
    chk("t1_count_after_push", 64'(count), 64'd1);
    wait_start("t1_start");
    chk("t1_write_addr", 64'(write_addr), 64'h04);
    chk("t1_write_data", 64'(write_data), 64'hDEAD_BEEF);
    chk("t1_write_strobe", 64'(write_strobe), 64'hF);
    @(negedge clk);
    chk("t1_start_one_cycle", 64'(write_start), 64'd0);
    wait_empty("t1_drain");
    chk("t1_mem", 64'(data_mem[1]), 64'hDEAD_BEEF);
    chk("t1_start_cnt", 64'(start_cnt), 64'd1);

    // 2: fill with master stalled, fifth store held until the first pop
    stall = 1'b1;
    base  = nlog;
    for (int i = 0; i < 4; i++) push(32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_ready_full", 64'(st_ready), 64'd0);
    st_valid  = 1'b1;
    st_addr   = 32'h10;
    st_data   = 32'hA000_0004;
    st_strobe = 4'hF;
    repeat (3) @(negedge clk);
    chk("t2_ready_hold", 64'(st_ready), 64'd0);
    chk("t2_count_hold", 64'(count), 64'd4);
    stall = 1'b0;
    wait_busy(1'b0, "t2_busy_drop");
    chk("t2_pop_cycle_ready", 64'(st_ready), 64'd0);
    @(negedge clk);
    chk("t2_ready_after_pop", 64'(st_ready), 64'd1);
    chk("t2_count_after_pop", 64'(count), 64'd3);
    @(negedge clk);
    st_valid  = 1'b0;
    st_strobe = '0;
    chk("t2_fifth_accepted", 64'(count), 64'd4);
    wait_empty("t2_drain");
    chk("t2_nlog", 64'(nlog - base), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_order_addr", 64'(log_addr[base + i]), 64'(4 * i));
      chk("t2_order_data", 64'(log_data[base + i]), 64'h0A000_0000 + 64'(i));
    end
    chk("t2_mem_last", 64'(data_mem[4]), 64'hA000_0004);

    // 3: partial strobe merge over zeroed word
    clr_word = 1'b1;
    @(negedge clk);
    clr_word = 1'b0;
    push(32'h08, 32'h1234_5678, 4'b1010);
    wait_empty("t3_drain");
    chk("t3_mem_partial", 64'(data_mem[2]), 64'h1200_5600);

    // 4: hazard
    stall = 1'b1;
    push(32'h0C, 32'h55AA_55AA, 4'hF);
    ld_addr = 32'h0E;
    #1 chk("t4_hazard_hit", 64'(ld_hazard), 64'd1);
    ld_addr = 32'h10;
    #1 chk("t4_hazard_miss", 64'(ld_hazard), 64'd0);
    ld_addr = 32'h0E;
    wait_busy(1'b1, "t4_busy_rise");
    #1 chk("t4_hazard_inflight", 64'(ld_hazard), 64'd1);
    stall = 1'b0;
    wait_empty("t4_drain");
    #1 chk("t4_hazard_cleared", 64'(ld_hazard), 64'd0);
    @(negedge clk);
    st_valid  = 1'b1;
    st_addr   = 32'h20;
    st_data   = 32'h0000_0020;
    st_strobe = 4'hF;
    ld_addr   = 32'h20;
    #1 chk("t4_same_cycle_push", 64'(ld_hazard), 64'd0);
    @(negedge clk);
    st_valid  = 1'b0;
    st_strobe = '0;
    #1 chk("t4_hazard_after_push", 64'(ld_hazard), 64'd1);
    wait_empty("t4_drain2");
    @(negedge clk);
    start0    = start_cnt;
    st_valid  = 1'b1;
    st_addr   = 32'h40;
    st_strobe = '0;
    ld_addr   = 32'h40;
    @(negedge clk);
    st_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_zero_strobe_count", 64'(count), 64'd0);
    chk("t4_zero_strobe_hazard", 64'(ld_hazard), 64'd0);
    chk("t4_zero_strobe_nostart", 64'(start_cnt), 64'(start0));

    // 5: push in the same cycle as the BUSY-to-IDLE pop
    stall = 1'b1;
    base  = nlog;
    push(32'h20, 32'hD000_0000, 4'hF);
    push(32'h24, 32'hD000_0001, 4'hF);
    wait_busy(1'b1, "t5_busy_rise");
    @(negedge clk);
    chk("t5_count_pre", 64'(count), 64'd2);
    stall = 1'b0;
    wait_busy(1'b0, "t5_busy_drop");
    st_valid  = 1'b1;
    st_addr   = 32'h28;
    st_data   = 32'hD000_0002;
    st_strobe = 4'hF;
    @(negedge clk);
    st_valid  = 1'b0;
    st_strobe = '0;
    chk("t5_count_same", 64'(count), 64'd2);
    wait_empty("t5_drain");
    for (int i = 0; i < 3; i++) begin
      chk("t5_order_addr", 64'(log_addr[base + i]), 64'h20 + 64'(4 * i));
      chk("t5_order_data", 64'(log_data[base + i]), 64'hD000_0000 + 64'(i));
    end

    // 6: reset while BUSY with 3 queued
    stall = 1'b1;
    base  = nlog;
    push(32'h30, 32'hE000_0000, 4'hF);
    push(32'h34, 32'hE000_0001, 4'hF);
    push(32'h38, 32'hE000_0002, 4'hF);
    wait_busy(1'b1, "t6_busy_rise");
    @(negedge clk);
    chk("t6_count_pre", 64'(count), 64'd3);
    ld_addr = 32'h30;
    #1 chk("t6_hazard_pre", 64'(ld_hazard), 64'd1);
    start0 = start_cnt;
    rst_n  = 1'b0;
    #1;
    chk("t6_rst_write_start", 64'(write_start), 64'd0);
    chk("t6_rst_count", 64'(count), 64'd0);
    chk("t6_rst_empty", 64'(empty), 64'd1);
    chk("t6_rst_ready", 64'(st_ready), 64'd1);
    chk("t6_rst_hazard", 64'(ld_hazard), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_no_writes", 64'(nlog), 64'(base));
    chk("t6_no_starts", 64'(start_cnt), 64'(start0));
    chk("t6_empty_after", 64'(empty), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_store_buffer.md
Name: axi4_lite_store_buffer

Overview:
Posted-write store buffer between the core's load/store unit and axi4_lite_write_master. It accepts CPU stores in one cycle, queues them in a DEPTH-entry FIFO of {addr, data, strobe}, and issues them one at a time to the write master through its write_start/write_busy handshake. It also flags read-after-write hazards so the LSU can stall loads that hit a pending store.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- st_valid  in  1  CPU store request
- st_addr  in  ADDR_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data, already lane-aligned
- st_strobe  in  DATA_WIDTH/8  byte enables
- st_ready  out  1  buffer can accept a store
- ld_addr  in  ADDR_WIDTH  address of the load in the LSU's current cycle
- ld_hazard  out  1  ld_addr word matches a pending or in-flight store
- write_start  out  1  one-cycle pulse to the write master
- write_addr  out  ADDR_WIDTH  to the write master
- write_data  out  DATA_WIDTH  to the write master
- write_strobe  out  DATA_WIDTH/8  to the write master
- write_busy  in  1  write master transaction in progress
- count  out  $clog2(DEPTH)+1  occupied entries, including the in-flight entry
- empty  out  1  count==0 and issue FSM in IDLE; used for fence/drain

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and count go to 0, FSM goes to IDLE, all entries become invalid.
  - Outputs: write_start=0; write_addr/write_data/write_strobe=0; st_ready=1; empty=1; ld_hazard=0.
- Push:
  - A store is accepted when st_valid && st_ready at posedge.
  - It is written at the tail and count increments.
  - st_ready = (count != DEPTH), computed from registered count only. A pop in the same cycle does not free a slot early.
  - A store with st_strobe==0 is accepted and discarded: no entry, count unchanged.
- Issue FSM:
  - IDLE: if count>0, load write_addr/data/strobe from the head, pulse write_start=1 for one cycle, go to ISSUE.
  - ISSUE: wait for write_busy==1, then go to BUSY. The write master must raise write_busy within 1 cycle of write_start.
  - BUSY: wait for write_busy==0, then pop the head (head++, count--) and go to IDLE.
  - Back-to-back: the next write_start occurs no earlier than the cycle after returning to IDLE.
  - Minimum issue spacing is 3 cycles beyond the master's busy duration.
- Output stability: write_addr/data/strobe are registered and held stable from write_start until the pop.
- Ordering: strictly FIFO; there is no store merging or reordering.
- Simultaneous push and pop: both take effect, so count is unchanged. With DEPTH entries full, the pop cycle still shows st_ready=0.
- Wrap-around: head and tail are $clog2(DEPTH)-bit pointers that wrap modulo DEPTH. Full versus empty is resolved by count.
- ld_hazard:
  - Combinational.
  - Asserts if any valid entry (in-flight head included) has addr[ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2].
  - It asserts regardless of strobe overlap.
  - The entry being pushed in the same cycle is not compared.
- empty: 1 only when count==0 and FSM==IDLE.
- Reset mid-transaction: the buffer and the write master share rst_n. All pending stores are lost and no completion is expected after reset.

Decomposition:
- Package axi4_lite_pkg holds:
  - the store_entry_t struct {addr, data, strobe};
  - the sb_state_t enum {SB_IDLE, SB_ISSUE, SB_BUSY};
  - the constant WORD_LSB=2.
- One sub-module is natural: sb_fifo, a generic parameterised FIFO with push/pop, head-entry read, and a flat vector of valid entries for the hazard comparators.
- The issue FSM and hazard logic stay in the top.

Test Plan:
1. Single store: reset, then st_valid with addr 0x04, data 0xDEADBEEF, strobe 4'b1111 for 1 cycle.
   Required: write_start pulses once carrying those values; data_mem word 0x04 reads 0xDEADBEEF; empty returns to 1.
2. Fill: 5 consecutive stores to 0x00, 0x04, 0x08, 0x0C, 0x10 with DEPTH=4 and the master stalled.
   Required: st_ready drops after the 4th store; the 5th is held until the first pop; data_mem receives all 5 in order.
3. Partial strobe: store 0x12345678 to 0x08 with strobe 4'b1010 over prior content 0.
   Required: data_mem word 0x08 reads 0x12005600.
4. Hazard: queue a store to 0x0C, then drive ld_addr=0x0E.
   Required: ld_hazard=1. With ld_addr=0x10, ld_hazard=0. After the store completes, ld_addr=0x0E gives ld_hazard=0.
5. Simultaneous push/pop: with count=2, push in the same cycle as the BUSY-to-IDLE pop.
   Required: count stays 2; order is preserved.
6. Reset mid-operation: deassert rst_n while in BUSY with 3 entries queued.
   Required: write_start=0, count=0, empty=1 immediately; no further writes reach data_mem after rst_n returns high.
